// File: rtl/sat_ctrl_pkg.sv
// Shared types and constants for the bin-partitioned SAT sequencer.
// The optional watchdog (CTRL_WATCHDOG_EN) uses WD_LIMIT and ST_ERR from here.
package sat_ctrl_pkg;

    localparam int DEF_BIN_W  = 16;
    localparam int DEF_LVL_W  = 16;
    localparam int DEF_CONF_W = 32;

    localparam logic [15:0] WD_LIMIT = 16'hFFFF;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'h0,
        ST_LOAD      = 4'h1,
        ST_BCP       = 4'h2,
        ST_DEC       = 4'h3,
        ST_ANA       = 4'h4,
        ST_BKT       = 4'h5,
        ST_UPD_SAT   = 4'h6,
        ST_UPD_UNSAT = 4'h7,
        ST_SAT       = 4'h8,
        ST_UNSAT     = 4'h9,
        ST_ABORT     = 4'hA,
        ST_ERR       = 4'hF
    } state_t;

    function automatic logic is_terminal(input state_t s);
        case (s)
            ST_SAT, ST_UNSAT, ST_ABORT, ST_ERR: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_pulse_gen.sv
// One-cycle start pulse on entry into TGT_A or TGT_B; registered so the
// pulse coincides with the first cycle spent in the target state.
module ctrl_pulse_gen
    import sat_ctrl_pkg::*;
#(
    parameter state_t TGT_A = ST_IDLE,
    parameter state_t TGT_B = TGT_A
) (
    input  logic   clk,
    input  logic   rst,
    input  state_t state,
    input  state_t next_state,
    output logic   pulse
);

    logic enter_s;

    assign enter_s = ((next_state == TGT_A) || (next_state == TGT_B)) && (next_state != state);

    // Pulse register
    always_ff @(posedge clk) begin
        if (!rst) begin
            pulse <= 1'b0;
        end else begin
            pulse <= enter_s;
        end
    end

endmodule

// File: rtl/sat_bin_ctrl.sv
// Top-level bin sequencer: walks clause bins and handshakes with the per-bin
// engines. Define CTRL_WATCHDOG_EN to add the per-state stall watchdog / ERR state.
module sat_bin_ctrl
    import sat_ctrl_pkg::*;
#(
    parameter int BIN_W         = DEF_BIN_W,
    parameter int LVL_W         = DEF_LVL_W,
    parameter int CONF_W        = DEF_CONF_W,
    parameter int MAX_CONFLICTS = 32'sd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BIN_W-1:0]  total_bins_i,
    output logic              done_o,
    output logic              sat_o,
    output logic              unsat_o,
    output logic              abort_o,
    output logic              load_start_o,
    output logic [BIN_W-1:0]  load_bin_o,
    input  logic              load_done_i,
    output logic              bcp_start_o,
    input  logic              bcp_done_i,
    input  logic              bcp_conflict_i,
    output logic              dec_start_o,
    input  logic              dec_done_i,
    input  logic              dec_all_assigned_i,
    output logic              ana_start_o,
    input  logic              ana_done_i,
    input  logic [BIN_W-1:0]  ana_bkt_bin_i,
    input  logic              ana_unsat_i,
    output logic              bkt_start_o,
    input  logic              bkt_done_i,
    output logic              upd_start_o,
    input  logic              upd_done_i,
    output logic [BIN_W-1:0]  cur_bin_o,
    output logic [3:0]        state_o,
    output logic [CONF_W-1:0] conflict_cnt_o,
    input  logic [LVL_W-1:0]  cur_level_i
);

    state_t             state_r, next_s;
    logic [BIN_W-1:0]   cur_bin_r, cur_bin_n;
    logic [BIN_W-1:0]   total_r, total_n;
    logic [BIN_W-1:0]   bkt_r, bkt_n;
    logic [CONF_W-1:0]  cnt_r, cnt_n, cnt_inc_s;
    logic               unused_level_s;

    function automatic logic [CONF_W-1:0] sat_inc(input logic [CONF_W-1:0] v);
        return (v == {CONF_W{1'b1}}) ? v : v + CONF_W'(1'b1);
    endfunction

    assign cnt_inc_s      = sat_inc(cnt_r);
    // Decision level is status-only; nothing in the sequencing depends on it.
    assign unused_level_s = ^cur_level_i;

`ifdef CTRL_WATCHDOG_EN
    logic [15:0] wd_r;
    logic        wd_active_s;

    assign wd_active_s = !is_terminal(state_r) && (state_r != ST_IDLE);

    // Per-state wait counter, restarted on every state change
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_r <= 16'd0;
        end else if (next_s != state_r) begin
            wd_r <= 16'd0;
        end else if (wd_active_s && (wd_r != WD_LIMIT)) begin
            wd_r <= wd_r + 16'd1;
        end else begin
            wd_r <= wd_r;
        end
    end
`endif

    // Next-state and datapath update; done is ignored while the start pulse is high
    always_comb begin
        next_s    = state_r;
        cur_bin_n = cur_bin_r;
        total_n   = total_r;
        bkt_n     = bkt_r;
        cnt_n     = cnt_r;
        case (state_r)
            ST_IDLE, ST_SAT, ST_UNSAT, ST_ABORT, ST_ERR: begin
                if (start) begin
                    cnt_n     = '0;
                    cur_bin_n = '0;
                    total_n   = total_bins_i;
                    next_s    = (total_bins_i == '0) ? ST_SAT : ST_LOAD;
                end else begin
                    next_s = state_r;
                end
            end
            ST_LOAD: begin
                if (load_done_i && !load_start_o) next_s = ST_BCP;
                else                              next_s = state_r;
            end
            ST_BCP: begin
                if (bcp_done_i && !bcp_start_o) next_s = bcp_conflict_i ? ST_ANA : ST_DEC;
                else                            next_s = state_r;
            end
            ST_DEC: begin
                if (dec_done_i && !dec_start_o) next_s = dec_all_assigned_i ? ST_UPD_SAT : ST_BCP;
                else                            next_s = state_r;
            end
            ST_ANA: begin
                if (ana_done_i && !ana_start_o) begin
                    cnt_n = cnt_inc_s;
                    bkt_n = ana_bkt_bin_i;
                    if (ana_unsat_i || (ana_bkt_bin_i >= total_r)) begin
                        next_s = ST_UNSAT;
                    end else if ((MAX_CONFLICTS > 32'sd0) && (cnt_inc_s == CONF_W'(MAX_CONFLICTS))) begin
                        next_s = ST_ABORT;
                    end else if (ana_bkt_bin_i != cur_bin_r) begin
                        next_s = ST_UPD_UNSAT;
                    end else begin
                        next_s = ST_BKT;
                    end
                end else begin
                    next_s = state_r;
                end
            end
            ST_BKT: begin
                if (bkt_done_i && !bkt_start_o) next_s = ST_BCP;
                else                            next_s = state_r;
            end
            ST_UPD_SAT: begin
                if (upd_done_i && !upd_start_o) begin
                    if (cur_bin_r == (total_r - BIN_W'(1'b1))) begin
                        next_s = ST_SAT;
                    end else begin
                        cur_bin_n = cur_bin_r + BIN_W'(1'b1);
                        next_s    = ST_LOAD;
                    end
                end else begin
                    next_s = state_r;
                end
            end
            ST_UPD_UNSAT: begin
                if (upd_done_i && !upd_start_o) begin
                    cur_bin_n = bkt_r;
                    next_s    = ST_LOAD;
                end else begin
                    next_s = state_r;
                end
            end
            default: next_s = ST_IDLE;
        endcase
`ifdef CTRL_WATCHDOG_EN
        if (wd_active_s && (wd_r == WD_LIMIT)) begin
            next_s = ST_ERR;
        end else begin
            next_s = next_s;
        end
`endif
    end

    // State, bookkeeping and registered result outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cur_bin_r  <= '0;
            total_r    <= '0;
            bkt_r      <= '0;
            cnt_r      <= '0;
            done_o     <= 1'b0;
            sat_o      <= 1'b0;
            unsat_o    <= 1'b0;
            abort_o    <= 1'b0;
            load_bin_o <= '0;
        end else begin
            state_r    <= next_s;
            cur_bin_r  <= cur_bin_n;
            total_r    <= total_n;
            bkt_r      <= bkt_n;
            cnt_r      <= cnt_n;
            done_o     <= is_terminal(next_s);
            sat_o      <= (next_s == ST_SAT);
            unsat_o    <= (next_s == ST_UNSAT);
            abort_o    <= (next_s == ST_ABORT) || (next_s == ST_ERR);
            load_bin_o <= (next_s == ST_LOAD) ? cur_bin_n : '0;
        end
    end

    assign state_o        = state_r;
    assign cur_bin_o      = cur_bin_r;
    assign conflict_cnt_o = cnt_r;

    ctrl_pulse_gen #(.TGT_A(ST_LOAD)) u_load_pulse (
        .clk(clk), .rst(rst), .state(state_r), .next_state(next_s), .pulse(load_start_o));
    ctrl_pulse_gen #(.TGT_A(ST_BCP)) u_bcp_pulse (
        .clk(clk), .rst(rst), .state(state_r), .next_state(next_s), .pulse(bcp_start_o));
    ctrl_pulse_gen #(.TGT_A(ST_DEC)) u_dec_pulse (
        .clk(clk), .rst(rst), .state(state_r), .next_state(next_s), .pulse(dec_start_o));
    ctrl_pulse_gen #(.TGT_A(ST_ANA)) u_ana_pulse (
        .clk(clk), .rst(rst), .state(state_r), .next_state(next_s), .pulse(ana_start_o));
    ctrl_pulse_gen #(.TGT_A(ST_BKT)) u_bkt_pulse (
        .clk(clk), .rst(rst), .state(state_r), .next_state(next_s), .pulse(bkt_start_o));
    ctrl_pulse_gen #(.TGT_A(ST_UPD_SAT), .TGT_B(ST_UPD_UNSAT)) u_upd_pulse (
        .clk(clk), .rst(rst), .state(state_r), .next_state(next_s), .pulse(upd_start_o));

endmodule

// File: tb/tb_sat_bin_ctrl.sv
// Self-checking bench for sat_bin_ctrl: the bench plays every engine, and a
// procedural solve-walk model predicts pulses, bins, counts and results.
module tb_sat_bin_ctrl;
    import sat_ctrl_pkg::*;

    localparam int BW = 16, LW = 16, CW = 32, MAXC = 2;
    localparam int E_LOAD = 0, E_BCP = 1, E_DEC = 2, E_ANA = 3, E_BKT = 4, E_UPD = 5;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [BW-1:0] total_bins_i;
    logic          done_o, sat_o, unsat_o, abort_o;
    logic          load_start_o, load_done_i;
    logic [BW-1:0] load_bin_o;
    logic          bcp_start_o, bcp_done_i, bcp_conflict_i;
    logic          dec_start_o, dec_done_i, dec_all_assigned_i;
    logic          ana_start_o, ana_done_i, ana_unsat_i;
    logic [BW-1:0] ana_bkt_bin_i;
    logic          bkt_start_o, bkt_done_i;
    logic          upd_start_o, upd_done_i;
    logic [BW-1:0] cur_bin_o;
    logic [3:0]    state_o;
    logic [CW-1:0] conflict_cnt_o;
    logic [LW-1:0] cur_level_i;

    int            checks = 0, failures = 0;
    int            script[$];
    int            loads[$];
    int            exp_q[$];
    int            n_upd, n_bkt;
    logic [CW-1:0] m_cnt;

    always #5 clk = ~clk;

    sat_bin_ctrl #(.BIN_W(BW), .LVL_W(LW), .CONF_W(CW), .MAX_CONFLICTS(MAXC)) dut (
        .clk(clk), .rst(rst), .start(start), .total_bins_i(total_bins_i),
        .done_o(done_o), .sat_o(sat_o), .unsat_o(unsat_o), .abort_o(abort_o),
        .load_start_o(load_start_o), .load_bin_o(load_bin_o), .load_done_i(load_done_i),
        .bcp_start_o(bcp_start_o), .bcp_done_i(bcp_done_i), .bcp_conflict_i(bcp_conflict_i),
        .dec_start_o(dec_start_o), .dec_done_i(dec_done_i), .dec_all_assigned_i(dec_all_assigned_i),
        .ana_start_o(ana_start_o), .ana_done_i(ana_done_i), .ana_bkt_bin_i(ana_bkt_bin_i),
        .ana_unsat_i(ana_unsat_i), .bkt_start_o(bkt_start_o), .bkt_done_i(bkt_done_i),
        .upd_start_o(upd_start_o), .upd_done_i(upd_done_i), .cur_bin_o(cur_bin_o),
        .state_o(state_o), .conflict_cnt_o(conflict_cnt_o), .cur_level_i(cur_level_i));

    initial begin
        #3000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

    function automatic logic [5:0] pulses();
        return {upd_start_o, bkt_start_o, ana_start_o, dec_start_o, bcp_start_o, load_start_o};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        start = 1'b0; load_done_i = 1'b0; bcp_done_i = 1'b0; dec_done_i = 1'b0;
        ana_done_i = 1'b0; bkt_done_i = 1'b0; upd_done_i = 1'b0;
    endtask

    task automatic set_done(input int eng, input logic v);
        case (eng)
            E_LOAD:  load_done_i = v;
            E_BCP:   bcp_done_i  = v;
            E_DEC:   dec_done_i  = v;
            E_ANA:   ana_done_i  = v;
            E_BKT:   bkt_done_i  = v;
            E_UPD:   upd_done_i  = v;
            default: ;
        endcase
    endtask

    // Stray dones for other engines, stray start, random data; own done low
    task automatic noise(input int own);
        load_done_i = ($urandom_range(0, 3) == 0); bcp_done_i = ($urandom_range(0, 3) == 0);
        dec_done_i  = ($urandom_range(0, 3) == 0); ana_done_i = ($urandom_range(0, 3) == 0);
        bkt_done_i  = ($urandom_range(0, 3) == 0); upd_done_i = ($urandom_range(0, 3) == 0);
        set_done(own, 1'b0);
        start = ($urandom_range(0, 3) == 0);
        total_bins_i = BW'($urandom_range(0, 7));
        bcp_conflict_i = 1'($urandom); dec_all_assigned_i = 1'($urandom);
        ana_unsat_i = 1'($urandom); ana_bkt_bin_i = BW'($urandom_range(0, 7));
        cur_level_i = LW'($urandom);
    endtask

    task automatic do_start(input int total);
        @(negedge clk);
        idle();
        start = 1'b1;
        total_bins_i = BW'(total);
        m_cnt = '0; loads.delete(); n_upd = 0; n_bkt = 0;
    endtask

    // One engine handshake: check the entry pulse, answer after 1..3 cycles
    task automatic stage(input int eng, input int bin, input logic conf, input logic all_a,
                         input int bkt, input logic uns);
        int         dly;
        logic [5:0] onehot;
        onehot = 6'b000001 << eng;
        @(negedge clk);
        chk($sformatf("pulse_e%0d", eng), pulses(), onehot);
        if (eng == E_LOAD) chk("load_bin", load_bin_o, bin);
        chk("cur_bin", cur_bin_o, bin);
        chk("conflict_cnt", conflict_cnt_o, m_cnt);
        chk("flags_busy", {done_o, sat_o, unsat_o, abort_o}, 4'b0000);
        noise(eng);
        set_done(eng, 1'b1);
        bcp_conflict_i = ~conf; dec_all_assigned_i = ~all_a; ana_unsat_i = ~uns;
        ana_bkt_bin_i = ~bkt[BW-1:0];
        dly = $urandom_range(1, 3);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            if (i == 0) chk("pulse_width", pulses(), 6'b000000);
            noise(eng);
            if (i == dly - 1) begin
                set_done(eng, 1'b1);
                bcp_conflict_i = conf; dec_all_assigned_i = all_a; ana_unsat_i = uns;
                ana_bkt_bin_i = bkt[BW-1:0];
            end
        end
    endtask

    task automatic check_term(input logic s, input logic u, input logic a);
        @(negedge clk);
        idle();
        chk("term_flags", {done_o, sat_o, unsat_o, abort_o}, {1'b1, s, u, a});
        chk("term_pulses", pulses(), 6'b000000);
        chk("term_cnt", conflict_cnt_o, m_cnt);
        repeat (3) begin
            @(negedge clk);
            noise(-1);
            start = 1'b0;
        end
        @(negedge clk);
        idle();
        chk("term_hold", {done_o, sat_o, unsat_o, abort_o}, {1'b1, s, u, a});
    endtask

    // Solve walk: bins in order, engines answered from the script or at random
    task automatic run_solve(input int total);
        int   bin, steps, v, bkt;
        logic c, a, u;
        do_start(total);
        if (total == 0) begin
            check_term(1'b1, 1'b0, 1'b0);
            return;
        end
        bin = 0; steps = 0;
        forever begin
            stage(E_LOAD, bin, 1'b0, 1'b0, 0, 1'b0);
            loads.push_back(bin);
            forever begin
                steps++;
                if (script.size() > 0) c = (script.pop_front() != 0);
                else c = (steps < 40) && ($urandom_range(0, 3) == 0);
                stage(E_BCP, bin, c, 1'b0, 0, 1'b0);
                if (c) begin
                    if (script.size() > 0) v = script.pop_front();
                    else v = (($urandom_range(0, 7) == 0) ? 32'h10000 : 32'h0) | $urandom_range(0, total);
                    u = v[16]; bkt = v & 32'hFFFF;
                    stage(E_ANA, bin, 1'b0, 1'b0, bkt, u);
                    if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1;
                    if (u || bkt >= total) begin check_term(1'b0, 1'b1, 1'b0); return; end
                    if (MAXC != 0 && m_cnt == MAXC) begin check_term(1'b0, 1'b0, 1'b1); return; end
                    if (bkt != bin) begin
                        stage(E_UPD, bin, 1'b0, 1'b0, 0, 1'b0);
                        n_upd++; bin = bkt;
                        break;
                    end
                    stage(E_BKT, bin, 1'b0, 1'b0, 0, 1'b0);
                    n_bkt++;
                end else begin
                    if (script.size() > 0) a = (script.pop_front() != 0);
                    else a = (steps > 40) || ($urandom_range(0, 1) == 0);
                    stage(E_DEC, bin, 1'b0, a, 0, 1'b0);
                    if (a) begin
                        stage(E_UPD, bin, 1'b0, 1'b0, 0, 1'b0);
                        n_upd++;
                        if (bin == total - 1) begin check_term(1'b1, 1'b0, 1'b0); return; end
                        bin++;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic chk_loads(input string tag);
        chk({tag, "_len"}, loads.size(), exp_q.size());
        foreach (exp_q[i]) if (i < loads.size()) chk($sformatf("%s_%0d", tag, i), loads[i], exp_q[i]);
    endtask

    initial begin
        rst = 1'b0;
        idle();
        total_bins_i = '0; bcp_conflict_i = 1'b0; dec_all_assigned_i = 1'b0;
        ana_unsat_i = 1'b0; ana_bkt_bin_i = '0; cur_level_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", state_o, ST_IDLE);
        chk("reset_flags_pulses", {done_o, sat_o, unsat_o, abort_o, pulses()}, 10'd0);
        chk("reset_cnt", conflict_cnt_o, 0);
        chk("reset_bins", {load_bin_o, cur_bin_o}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_no_start", state_o, ST_IDLE);

        // Three clean bins
        script = '{0, 1, 0, 1, 0, 1};
        run_solve(3);
        exp_q = '{0, 1, 2};
        chk_loads("t1_loads");
        chk("t1_upd", n_upd, 3);

        // Conflict in bin 2 backtracks to bin 0
        script = '{0, 1, 0, 1, 1, 0, 0, 1, 0, 1, 0, 1, 0, 1};
        run_solve(4);
        exp_q = '{0, 1, 2, 0, 1, 2, 3};
        chk_loads("t2_loads");
        chk("t2_cnt", conflict_cnt_o, 1);

        // Local conflict in bin 1: BKT then BCP, no reload
        script = '{0, 1, 1, 1, 0, 1, 0, 1};
        run_solve(3);
        exp_q = '{0, 1, 2};
        chk_loads("t3_loads");
        chk("t3_bkt", n_bkt, 1);

        // Budget of two conflicts
        script = '{1, 0, 1, 0};
        run_solve(2);
        chk("t4_bkt", n_bkt, 1);

        // Analysis reports UNSAT, then a fresh solve clears flags
        script = '{1, 32'h10000};
        run_solve(2);
        script = '{0, 1};
        run_solve(1);
        exp_q = '{0};
        chk_loads("t5_loads");

        // Backtrack bin out of range
        script = '{1, 5};
        run_solve(2);

        run_solve(0);
        chk("script_consumed", script.size(), 0);

        // Reset in BCP after one conflict
        do_start(3);
        stage(E_LOAD, 0, 1'b0, 1'b0, 0, 1'b0);
        stage(E_BCP, 0, 1'b1, 1'b0, 0, 1'b0);
        stage(E_ANA, 0, 1'b0, 1'b0, 0, 1'b0);
        m_cnt = 1;
        stage(E_BKT, 0, 1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        chk("rst_pre_bcp", pulses(), 6'b000010);
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("rst_state", state_o, ST_IDLE);
        chk("rst_flags_pulses", {done_o, sat_o, unsat_o, abort_o, pulses()}, 10'd0);
        chk("rst_cnt", conflict_cnt_o, 0);
        chk("rst_bins", {load_bin_o, cur_bin_o}, 0);
        rst = 1'b1;

        for (int r = 0; r < 25; r++) run_solve($urandom_range(1, 5));

`ifdef CTRL_WATCHDOG_EN
        begin
            int waited;
            do_start(1);
            stage(E_LOAD, 0, 1'b0, 1'b0, 0, 1'b0);
            @(negedge clk);
            idle();
            chk("wd_bcp", pulses(), 6'b000010);
            waited = 0;
            while (!done_o && waited < 70000) begin
                @(negedge clk);
                waited++;
            end
            chk("wd_flags", {done_o, sat_o, unsat_o, abort_o}, 4'b1001);
            chk("wd_state", state_o, ST_ERR);
            script = '{0, 1};
            run_solve(1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sat_bin_ctrl.md
# sat_bin_ctrl

Parametrised top-level sequencer for the bin-partitioned SAT engine. It walks the clause bins in order and drives the load, BCP, decision, analysis, backtrack and update engines through one-cycle start pulses and done handshakes. It moves between bins on partial SAT or UNSAT and reports global SAT, UNSAT or abort. It sits above the per-bin datapath and replaces the fixed-width bin controller.

## Interface
- BIN_W, 16, width of bin indices and bin count
- LVL_W, 16, width of decision level
- CONF_W, 32, width of conflict counter
- MAX_CONFLICTS, 0, conflict budget; 0 = unlimited
- clk in 1 clock
- rst in 1 reset; synchronous, active-low; clock clk
- start in 1 begin solve; honoured only in IDLE or a terminal state
- total_bins_i in BIN_W number of bins; sampled on accepted start
- done_o / sat_o / unsat_o / abort_o out 1 each; sticky result flags
- load_start_o out 1 load pulse; load_bin_o out BIN_W bin to load; load_done_i in 1
- bcp_start_o out 1; bcp_done_i in 1; bcp_conflict_i in 1 (valid with done)
- dec_start_o out 1; dec_done_i in 1; dec_all_assigned_i in 1 (valid with done)
- ana_start_o out 1; ana_done_i in 1; ana_bkt_bin_i in BIN_W; ana_unsat_i in 1 (valid with done)
- bkt_start_o out 1; bkt_done_i in 1
- upd_start_o out 1; upd_done_i in 1
- cur_bin_o out BIN_W current bin; state_o out 4 current state
- conflict_cnt_o out CONF_W conflicts seen, saturating
- cur_level_i in LVL_W decision level, observed for status only

## Operation
- States: IDLE, LOAD, BCP, DEC, ANA, BKT, UPD_SAT, UPD_UNSAT, SAT, UNSAT, ABORT, and ERR (watchdog only).
- IDLE/terminal + start: clear the flags, set cur_bin=0, go to LOAD. If total_bins_i==0, go directly to SAT.
- LOAD, on load_done_i: go to BCP.
- BCP, on done: conflict goes to ANA, otherwise DEC.
- DEC, on done: dec_all_assigned_i goes to UPD_SAT, otherwise BCP.
- ANA, on done: increment conflict_cnt. Then, by priority:
  - ana_unsat_i=1 or ana_bkt_bin_i ≥ total_bins: UNSAT.
  - Budget reached (MAX_CONFLICTS≠0 and count==MAX_CONFLICTS): ABORT.
  - ana_bkt_bin_i≠cur_bin: UPD_UNSAT.
  - Otherwise: BKT.
- BKT, on done: go to BCP.
- UPD_SAT, on done: if cur_bin==total_bins−1, go to SAT; otherwise cur_bin+1 and LOAD.
- UPD_UNSAT, on done: cur_bin=ana_bkt_bin (latched at ANA done), then LOAD.
- Terminal states hold. done_o=1 plus exactly one of sat_o/unsat_o/abort_o.
- load_bin_o is valid while in LOAD and equals cur_bin.

## Timing
- All outputs are registered. Reset value of every output is 0; state is IDLE.
- Each *_start_o is high for exactly one cycle: the first cycle of the corresponding state, including on re-entry (e.g. BCP→DEC→BCP produces two bcp pulses).
- Done inputs are ignored in the start cycle and in states they do not belong to. A transition takes effect the cycle after done is sampled.
- Minimum stage latency is 2 cycles (start pulse, then done at the earliest the next cycle).
- start while busy: ignored.
- Reset mid-operation: IDLE on the next edge, all pulses and flags cleared, counters zeroed.
- Result flags assert in the cycle the terminal state is entered and persist until the next accepted start.
- conflict_cnt saturates at all-ones; it does not wrap.

## Configuration
- CTRL_WATCHDOG_EN defined: adds a 16-bit per-state wait counter, cleared on every state change. If it reaches 0xFFFF in any non-terminal, non-IDLE state, the controller enters ERR, which sets done_o=1 and abort_o=1 and holds until start.
- Undefined: no counter and no ERR state; the controller waits indefinitely for done.

## Structure
- Package sat_ctrl_pkg holds:
  - the state enum (4-bit encoding, ERR=4'hF)
  - the default widths
  - the watchdog limit constant
- Sub-module ctrl_pulse_gen: state-entry detector producing the one-cycle start pulses; one instance per engine.

## Test plan
- total_bins=3, no conflicts, DEC reports all assigned per bin → load_bin sequence 0,1,2; 3 upd pulses; sat_o=1, done_o=1.
- total_bins=4, bin 2 conflict with ana_bkt_bin=0 → UPD_UNSAT, then load_bin=0; conflict_cnt=1.
- Conflict with bkt_bin==cur_bin=1 → bkt_start pulse, then BCP re-entry, no load.
- MAX_CONFLICTS=2, repeated local conflicts → second ANA done gives abort_o=1, sat_o=unsat_o=0.
- ana_unsat_i=1 → unsat_o=1; start again → flags clear, load_bin=0.
- Reset asserted in BCP; with CTRL_WATCHDOG_EN, hold bcp_done low for 65535 cycles → IDLE with outputs 0; separately, ERR with abort_o=1.
